// File: rtl/jtag_reg_bridge.sv
// JTAG user-DR (ER1) to valid/ready register-bus bridge; everything runs on JTCK.
// Optional response timeout is enabled by defining JTAG_REG_BRIDGE_TIMEOUT_EN.
module jtag_reg_bridge #(
    parameter int ADDR_W         = 7,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              JTCK,
    input  logic              JRSTN,
    input  logic              JTDI,
    input  logic              JSHIFT,
    input  logic              JUPDATE,
    input  logic              JCE1,
    output logic              JTDO1,
    output logic              req_valid,
    output logic              req_write,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata
);
    localparam int L = 2 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [L-1:0]      sr_q, sr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              armed_q, armed_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              req_valid_q, req_valid_d;
    logic              req_write_q, req_write_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic capture, shift, update;

    always_comb begin
        capture     = JCE1 && !JSHIFT;
        shift       = JCE1 && JSHIFT;
        update      = !JCE1 && JUPDATE && armed_q;

        sr_d        = sr_q;
        rdata_d     = rdata_q;
        armed_d     = armed_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        state_d     = state_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;

        if (capture) begin
            sr_d      = {rdata_q, {(ADDR_W-1){1'b0}}, timeout_q, overrun_q, state_q != IDLE};
            armed_d   = 1'b1;
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end else if (shift) begin
            sr_d = {JTDI, sr_q[L-1:1]};
        end

        case (state_q)
            REQ: begin
                if (req_ready) begin
                    state_d = req_write_q ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rsp_valid) begin
                    rdata_d = rsp_rdata;
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
        // A normal completion in the same cycle wins over the abort.
        if (state_q != IDLE && state_d == state_q && cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            if (!req_write_q) begin
                rdata_d = {DATA_W{1'b1}};
            end
        end
`endif

        if (update) begin
            armed_d = 1'b0;
            if (sr_q[1]) begin
                if (state_q == IDLE) begin
                    state_d     = REQ;
                    req_write_d = sr_q[0];
                    req_addr_d  = sr_q[ADDR_W+1:2];
                    req_wdata_d = sr_q[L-1:ADDR_W+2];
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end

`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
        cnt_d = (state_d != state_q || state_d == IDLE) ? '0 : cnt_q + 1'b1;
`endif
        req_valid_d = (state_d == REQ);
    end

    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            rdata_q     <= '0;
            armed_q     <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            rdata_q     <= rdata_d;
            armed_q     <= armed_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign JTDO1     = sr_q[0];
    assign req_valid = req_valid_q;
    assign req_write = req_write_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;

endmodule
